// File: rtl/rename_alloc_ctrl_pkg.sv
// Shared rename-stage definitions: physical register file sizing and the
// allocation controller's state encoding.
package rename_alloc_ctrl_pkg;

  localparam int PRF_NUM       = 64;
  localparam int PRF_NUM_WIDTH = 6;

  typedef logic [PRF_NUM_WIDTH-1:0] PRFNum;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/rename_alloc_ctrl_sat_counter.sv
// Saturating up-counter used for the rename-stage stall statistics.
// Holds at all-ones instead of wrapping; clr has priority over inc.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/rename_alloc_ctrl.sv
// Rename-stage free-list allocation controller: gates two-wide PRF allocation
// on pair acceptance, holds the result in a one-entry output stage.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_RUN     | normal operation, pairs may fire
// ST_RECOVER | post-mispredict window: no accept, no allocation, frees only
module rename_alloc_ctrl
  import rename_alloc_ctrl_pkg::*;
#(
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 recover,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_slot_valid,
  input  logic [1:0]           in_need_prf,
  output logic                 fl_req_0,
  output logic                 fl_req_1,
  input  logic                 fl_allocatable,
  input  PRFNum                fl_prf_0,
  input  PRFNum                fl_prf_1,
  output logic                 fl_pause,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_slot_valid,
  output PRFNum                out_prf_0,
  output PRFNum                out_prf_1,
  output logic [CNT_WIDTH-1:0] stall_fl_cnt,
  output logic [CNT_WIDTH-1:0] stall_out_cnt
);

  localparam int TW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RECOVER_CYCLES - 1);

  alloc_state_e   state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           out_valid_q, out_valid_d;
  logic [1:0]     out_slot_valid_q, out_slot_valid_d;
  PRFNum          out_prf_0_q, out_prf_0_d;
  PRFNum          out_prf_1_q, out_prf_1_d;

  logic       run;
  logic       can_accept;
  logic       fire;
  logic [1:0] need;
  logic       stall_fl_inc;
  logic       stall_out_inc;

  always_comb begin
    run           = (state_q == ST_RUN) && !recover && !rst;
    can_accept    = !out_valid_q || out_ready;
    need          = in_slot_valid & in_need_prf;
    fl_req_0      = in_valid && need[0] && run;
    fl_req_1      = in_valid && need[1] && run;
    fire          = in_valid && can_accept && fl_allocatable && run;
    in_ready      = fire;
    fl_pause      = !fire;
    stall_fl_inc  = in_valid && run && can_accept && !fl_allocatable;
    stall_out_inc = in_valid && run && !can_accept;
  end

  // The recover pulse cycle is the first cycle of the window, so RECOVER is
  // left once the timer reaches its last count.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (recover) begin
      state_d = ST_RECOVER;
      timer_d = TIMER_LOAD;
    end else if (state_q == ST_RECOVER) begin
      if (timer_q <= TW'(1)) begin
        state_d = ST_RUN;
        timer_d = '0;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end
  end

  always_comb begin
    out_valid_d      = out_valid_q;
    out_slot_valid_d = out_slot_valid_q;
    out_prf_0_d      = out_prf_0_q;
    out_prf_1_d      = out_prf_1_q;
    if (fire) begin
      out_valid_d      = 1'b1;
      out_slot_valid_d = in_slot_valid;
      out_prf_0_d      = need[0] ? fl_prf_0 : '0;
      out_prf_1_d      = need[1] ? fl_prf_1 : '0;
    end else if (recover || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      timer_q          <= '0;
      out_valid_q      <= 1'b0;
      out_slot_valid_q <= '0;
      out_prf_0_q      <= '0;
      out_prf_1_q      <= '0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      out_valid_q      <= out_valid_d;
      out_slot_valid_q <= out_slot_valid_d;
      out_prf_0_q      <= out_prf_0_d;
      out_prf_1_q      <= out_prf_1_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_slot_valid = out_slot_valid_q;
  assign out_prf_0      = out_prf_0_q;
  assign out_prf_1      = out_prf_1_q;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_fl_cnt (
    .clk   (clk),
    .inc   (stall_fl_inc),
    .clr   (rst),
    .count (stall_fl_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_out_cnt (
    .clk   (clk),
    .inc   (stall_out_inc),
    .clr   (rst),
    .count (stall_out_cnt)
  );

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl: expected output pairs are queued at
// stimulus time and checked by an independent monitor on each transfer.
module tb_rename_alloc_ctrl;
  import rename_alloc_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          recover;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_slot_valid;
  logic [1:0]    in_need_prf;
  logic          fl_req_0, fl_req_1;
  logic          fl_allocatable;
  PRFNum         fl_prf_0, fl_prf_1;
  logic          fl_pause;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_slot_valid;
  PRFNum         out_prf_0, out_prf_1;
  logic [CW-1:0] stall_fl_cnt, stall_out_cnt;

  rename_alloc_ctrl #(.RECOVER_CYCLES(2), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .recover        (recover),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_slot_valid  (in_slot_valid),
    .in_need_prf    (in_need_prf),
    .fl_req_0       (fl_req_0),
    .fl_req_1       (fl_req_1),
    .fl_allocatable (fl_allocatable),
    .fl_prf_0       (fl_prf_0),
    .fl_prf_1       (fl_prf_1),
    .fl_pause       (fl_pause),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_slot_valid (out_slot_valid),
    .out_prf_0      (out_prf_0),
    .out_prf_1      (out_prf_1),
    .stall_fl_cnt   (stall_fl_cnt),
    .stall_out_cnt  (stall_out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sv;
    PRFNum      p0;
    PRFNum      p1;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cmb(input string n, input int rdy, input int req, input int pause);
    chk({n, "_in_ready"}, int'(in_ready), rdy);
    chk({n, "_fl_req"}, int'({fl_req_1, fl_req_0}), req);
    chk({n, "_fl_pause"}, int'(fl_pause), pause);
  endtask

  task automatic push(input logic [1:0] sv, input int p0, input int p1);
    exp_t e;
    e.sv = sv;
    e.p0 = PRFNum'(p0);
    e.p1 = PRFNum'(p1);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sv, input logic [1:0] need, input int p0, input int p1);
    in_valid      = 1'b1;
    in_slot_valid = sv;
    in_need_prf   = need;
    fl_prf_0      = PRFNum'(p0);
    fl_prf_1      = PRFNum'(p1);
  endtask

  // Monitor: every accepted output pair must match the oldest queued pair.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output slot=%0d prf0=%0d prf1=%0d expected=none",
                 out_slot_valid, out_prf_0, out_prf_1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_out_slot_valid", int'(out_slot_valid), int'(mon_e.sv));
        chk("mon_out_prf_0", int'(out_prf_0), int'(mon_e.p0));
        chk("mon_out_prf_1", int'(out_prf_1), int'(mon_e.p1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; recover = 1'b0; out_ready = 1'b1; fl_allocatable = 1'b1;
    drive(2'b11, 2'b11, 5, 6);

    // Reset: combinational gating and register reset values.
    @(negedge clk); cmb("rst", 0, 0, 1);
    step();
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_slot_valid", int'(out_slot_valid), 0);
    chk("rst_out_prf_0", int'(out_prf_0), 0);
    chk("rst_out_prf_1", int'(out_prf_1), 0);
    chk("rst_stall_fl", int'(stall_fl_cnt), 0);
    chk("rst_stall_out", int'(stall_out_cnt), 0);
    step();
    rst = 1'b0;

    // Both slots need a PRF.
    @(negedge clk); cmb("t1_fire", 1, 3, 0); push(2'b11, 5, 6);
    step(); in_valid = 1'b0;
    @(negedge clk); chk("t1_out_valid", int'(out_valid), 1); cmb("t1_idle", 0, 0, 1);
    step();

    // Only slot 0 needs a PRF.
    drive(2'b11, 2'b01, 9, 7);
    @(negedge clk); cmb("t2_fire", 1, 1, 0); push(2'b11, 9, 0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    step();

    // Free list short for three cycles.
    drive(2'b11, 2'b11, 10, 11); fl_allocatable = 1'b0;
    repeat (3) begin
      @(negedge clk); cmb("t3_stall", 0, 3, 1);
      step();
    end
    fl_allocatable = 1'b1;
    @(negedge clk); cmb("t3_fire", 1, 3, 0); chk("t3_stall_fl", int'(stall_fl_cnt), 3);
    push(2'b11, 10, 11);
    step(); in_valid = 1'b0;
    @(negedge clk); cmb("t3_single", 0, 0, 1);
    step();

    // Output stage full for four cycles.
    out_ready = 1'b0;
    drive(2'b01, 2'b01, 20, 21);
    @(negedge clk); cmb("t4_fire", 1, 1, 0); push(2'b01, 20, 0);
    step();
    drive(2'b11, 2'b11, 22, 23);
    repeat (4) begin
      @(negedge clk); cmb("t4_hold", 0, 3, 1); chk("t4_held_prf_0", int'(out_prf_0), 20);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk); cmb("t4_release", 1, 3, 0); chk("t4_stall_out", int'(stall_out_cnt), 4);
    push(2'b11, 22, 23);
    step();

    // Recover while a pair is held and another is offered.
    drive(2'b11, 2'b11, 30, 31); recover = 1'b1;
    @(negedge clk); cmb("t5_rec", 0, 0, 1);
    step(); recover = 1'b0;
    @(negedge clk); chk("t5_out_valid", int'(out_valid), 0); cmb("t5_win", 0, 0, 1);
    step();
    @(negedge clk); cmb("t5_resume", 1, 3, 0); push(2'b11, 30, 31);
    step();

    // Second recover inside the window extends it.
    drive(2'b11, 2'b11, 40, 41); recover = 1'b1;
    @(negedge clk); cmb("t6_rec1", 0, 0, 1);
    step();
    @(negedge clk); cmb("t6_rec2", 0, 0, 1);
    step(); recover = 1'b0;
    @(negedge clk); cmb("t6_win", 0, 0, 1);
    step();
    @(negedge clk); cmb("t6_resume", 1, 3, 0); push(2'b11, 40, 41);
    step();

    // Stall counter saturation: 3 + 12 reaches all-ones, then holds.
    fl_allocatable = 1'b0;
    repeat (12) begin
      @(negedge clk);
      step();
    end
    @(negedge clk); chk("t7_sat", int'(stall_fl_cnt), 15);
    repeat (5) step();
    @(negedge clk); chk("t7_no_wrap", int'(stall_fl_cnt), 15);
    chk("t7_stall_out", int'(stall_out_cnt), 4);
    step();

    // Pair with no destinations still fires, PRFs forced to zero.
    fl_allocatable = 1'b1;
    drive(2'b11, 2'b00, 50, 51);
    @(negedge clk); cmb("t8_fire", 1, 0, 0); push(2'b11, 0, 0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    step();

    // Reset clears the counters.
    rst = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_stall_fl", int'(stall_fl_cnt), 0);
    chk("rst2_stall_out", int'(stall_out_cnt), 0);
    rst = 1'b0;
    step();

    chk("pending_pairs", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
